// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with tree-PLRU replacement.
// A stage-2 lookup register, a burst refill FSM and an uncached bypass path.
module icache_nway #(
    parameter int          WAYS       = 2,
    parameter int          SETS       = 256,
    parameter int          LINE_WORDS = 4,
    parameter logic [3:0]  RID        = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        invalidate,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        req_uncached,
    output logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_req_o,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    input  logic [31:0] ram_data_i,
    input  logic [3:0]  rid,
    input  logic        rvalid,
    input  logic        rlast
);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int WRD_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_REFILL, ST_WRITE, ST_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic                   s2_valid_q, s2_unc_q;
    logic [31:0]            s2_addr_q, araddr_q;
    logic [3:0]             arlen_q;
    logic [WRD_W-1:0]       cnt_q;
    logic [31:0]            buf_q   [LINE_WORDS];
    logic [SETS-1:0]        valid_q [WAYS];
    logic [WAYS-2:0]        plru_q  [SETS];
    logic [TAG_W-1:0]       tag_q   [WAYS][SETS];
    logic [31:0]            data_q  [WAYS][SETS][LINE_WORDS];

    logic [IDX_W-1:0]       s2_idx;
    logic [TAG_W-1:0]       s2_tag;
    logic [WRD_W-1:0]       s2_word;
    logic                   hit, inv_found, own_beat, own_last;
    logic [WAY_W-1:0]       hit_way, inv_way, victim;
    logic                   do_hit, do_write;
    logic [31:0]            word;

    // Tree bits point toward the next victim; touching a way flips its path away.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0]  b;
        logic [WAY_W-1:0] node;
        b    = bits;
        node = WAY_W'(1);
        for (int l = 0; l < WAY_W; l++) begin
            b[node - 1'b1] = ~way[WAY_W-1-l];
            node = (node << 1) | WAY_W'(way[WAY_W-1-l]);
        end
        return b;
    endfunction

    function automatic logic [WAY_W-1:0] plru_pick(input logic [WAYS-2:0] bits);
        logic [WAY_W-1:0] node, v;
        node = WAY_W'(1);
        v    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            v[WAY_W-1-l] = bits[node - 1'b1];
            node = (node << 1) | WAY_W'(bits[node - 1'b1]);
        end
        return v;
    endfunction

    assign s2_idx   = s2_addr_q[OFF_W +: IDX_W];
    assign s2_tag   = s2_addr_q[31 -: TAG_W];
    assign s2_word  = s2_addr_q[2 +: WRD_W];
    assign own_beat = rvalid && (rid == RID);
    assign own_last = own_beat && rlast;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][s2_idx] && tag_q[w][s2_idx] == s2_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][s2_idx]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : plru_pick(plru_q[s2_idx]);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!clear && s2_valid_q && (s2_unc_q || !hit)) state_d = ST_REFILL;
            ST_REFILL: begin
                if (clear)         state_d = own_last ? ST_IDLE : ST_DRAIN;
                else if (own_last) state_d = s2_unc_q ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE:  state_d = ST_IDLE;
            ST_DRAIN:  if (own_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        inst_valid = 1'b0;
        inst_req_o = 1'b0;
        do_hit     = 1'b0;
        do_write   = 1'b0;
        word       = '0;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    stall = 1'b1;
                end else if (s2_valid_q) begin
                    if (!s2_unc_q && hit) begin
                        inst_valid = 1'b1;
                        do_hit     = 1'b1;
                        word       = data_q[hit_way][s2_idx][s2_word];
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            ST_REFILL: begin
                if (clear) begin
                    stall = 1'b1;
                end else if (own_last && s2_unc_q) begin
                    inst_valid = 1'b1;
                    word       = ram_data_i;
                end else begin
                    stall      = 1'b1;
                    inst_req_o = !own_last;
                end
            end
            ST_WRITE: begin
                if (clear) begin
                    stall = 1'b1;
                end else begin
                    inst_valid = 1'b1;
                    do_write   = 1'b1;
                    word       = buf_q[s2_word];
                end
            end
            ST_DRAIN: stall = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    assign inst_o      = inst_valid ? word : 32'd0;
    assign inst_addr_o = inst_valid ? s2_addr_q : 32'd0;
    assign araddr      = araddr_q;
    assign arlen       = arlen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s2_valid_q <= 1'b0;
            s2_unc_q   <= 1'b0;
            s2_addr_q  <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            cnt_q      <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                s2_valid_q <= 1'b0;
            end else if (!stall) begin
                s2_valid_q <= req_valid;
                s2_addr_q  <= req_addr;
                s2_unc_q   <= req_uncached;
            end
            if (state_q == ST_IDLE && state_d == ST_REFILL) begin
                araddr_q <= s2_unc_q ? s2_addr_q : {s2_addr_q[31:OFF_W], {OFF_W{1'b0}}};
                arlen_q  <= s2_unc_q ? 4'd0 : 4'(LINE_WORDS - 1);
                cnt_q    <= '0;
            end else if (state_q == ST_REFILL && own_beat) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Invalidate wins over a coincident allocation.
            if (invalidate) begin
                for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
            end else if (do_write) begin
                valid_q[victim][s2_idx] <= 1'b1;
                plru_q[s2_idx]          <= plru_touch(plru_q[s2_idx], victim);
            end else if (do_hit) begin
                plru_q[s2_idx] <= plru_touch(plru_q[s2_idx], hit_way);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_REFILL && own_beat) buf_q[cnt_q] <= ram_data_i;
        if (do_write) begin
            tag_q[victim][s2_idx] <= s2_tag;
            for (int k = 0; k < LINE_WORDS; k++) data_q[victim][s2_idx][k] <= buf_q[k];
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway (2 ways, 256 sets, 4-word lines): directed scenarios plus
// random fetches checked against an LRU-list cache model and a hashed memory.
module tb_icache_nway;
    logic        clk = 1'b0;
    logic        rst, clear, invalidate, req_valid, req_uncached;
    logic [31:0] req_addr, ram_data_i;
    logic [3:0]  rid;
    logic        rvalid, rlast;
    logic        stall, inst_valid, inst_req_o;
    logic [31:0] inst_o, inst_addr_o, araddr;
    logic [3:0]  arlen;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] salt;

    // Model: per set, MRU and LRU line addresses (addr >> 4) and a fill count.
    logic [27:0] mru_m [256];
    logic [27:0] lru_m [256];
    int          cnt_m [256];

    icache_nway dut (
        .clk(clk), .rst(rst), .clear(clear), .invalidate(invalidate),
        .req_valid(req_valid), .req_addr(req_addr), .req_uncached(req_uncached),
        .stall(stall), .inst_valid(inst_valid), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .inst_req_o(inst_req_o),
        .araddr(araddr), .arlen(arlen), .ram_data_i(ram_data_i),
        .rid(rid), .rvalid(rvalid), .rlast(rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        logic [27:0] line;
        int          s;
        line = a[31:4];
        s    = int'(a[11:4]);
        return (cnt_m[s] >= 1 && mru_m[s] == line) || (cnt_m[s] == 2 && lru_m[s] == line);
    endfunction

    task automatic model_touch(input logic [31:0] a);
        int s;
        s = int'(a[11:4]);
        if (cnt_m[s] == 2 && lru_m[s] == a[31:4]) begin
            lru_m[s] = mru_m[s];
            mru_m[s] = a[31:4];
        end
    endtask

    task automatic model_fill(input logic [31:0] a);
        int s;
        s = int'(a[11:4]);
        lru_m[s] = mru_m[s];
        mru_m[s] = a[31:4];
        cnt_m[s] = (cnt_m[s] < 2) ? cnt_m[s] + 1 : 2;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 256; s++) cnt_m[s] = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_beat();
        rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; ram_data_i = 32'd0;
    endtask

    // Present one request, then service its lookup / burst and check every output step.
    task automatic fetch(input logic [31:0] addr, input bit unc);
        bit          hit;
        int          n, waitc;
        logic [31:0] base;
        hit = !unc && model_hit(addr);
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_uncached = unc;
        #1;
        waitc = 0;
        while (stall !== 1'b0 && waitc < 20) begin
            @(negedge clk); #1; waitc++;
        end
        chk("accept_stall", stall, 0);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'd0; req_uncached = 1'b0;
        #1;
        if (hit) begin
            chk("hit_valid", inst_valid, 1);
            chk("hit_data", inst_o, mem_word(addr));
            chk("hit_addr", inst_addr_o, addr);
            chk("hit_no_req", inst_req_o, 0);
            model_touch(addr);
            return;
        end
        chk("miss_stall", stall, 1);
        chk("miss_no_inst", inst_valid, 0);
        @(negedge clk); #1;
        base = unc ? addr : {addr[31:4], 4'h0};
        n    = unc ? 1 : 4;
        chk("refill_req", inst_req_o, 1);
        chk("araddr", araddr, base);
        chk("arlen", {28'd0, arlen}, n - 1);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                rvalid = 1'b1; rid = 4'b0001; rlast = 1'($urandom_range(0, 1));
                ram_data_i = $urandom;
                #1;
                chk("foreign_req", inst_req_o, 1);
                chk("foreign_stall", stall, 1);
                @(negedge clk);
            end
            rvalid = 1'b1; rid = 4'b0000; rlast = (k == n - 1);
            ram_data_i = mem_word(base + 32'(4 * k));
            #1;
            if (k == n - 1) begin
                chk("last_req", inst_req_o, 0);
                if (unc) begin
                    chk("unc_valid", inst_valid, 1);
                    chk("unc_data", inst_o, mem_word(addr));
                    chk("unc_addr", inst_addr_o, addr);
                    chk("unc_stall", stall, 0);
                end else begin
                    chk("last_stall", stall, 1);
                end
            end else begin
                chk("beat_stall", stall, 1);
            end
            @(negedge clk);
        end
        idle_beat();
        if (!unc) begin
            #1;
            chk("write_valid", inst_valid, 1);
            chk("write_data", inst_o, mem_word(addr));
            chk("write_addr", inst_addr_o, addr);
            chk("write_stall", stall, 0);
            model_fill(addr);
        end
    endtask

    // Two back-to-back requests, one accepted per cycle.
    task automatic hit_pair(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_uncached = 1'b0;
        #1;
        chk("pair_accept", stall, 0);
        @(negedge clk);
        req_addr = b;
        #1;
        chk("pair_a_valid", inst_valid, 32'(model_hit(a)));
        chk("pair_a_data", inst_o, mem_word(a));
        chk("pair_b_accept", stall, 0);
        model_touch(a);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'd0;
        #1;
        chk("pair_b_valid", inst_valid, 32'(model_hit(b)));
        chk("pair_b_data", inst_o, mem_word(b));
        model_touch(b);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_valid"}, inst_valid, 0);
        chk({tag, "_inst"}, inst_o, 0);
        chk({tag, "_iaddr"}, inst_addr_o, 0);
        chk({tag, "_req"}, inst_req_o, 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_arlen"}, {28'd0, arlen}, 0);
    endtask

    initial begin
        logic [31:0] a;
        salt = $urandom;
        model_reset();
        rst = 1'b1; clear = 1'b0; invalidate = 1'b0;
        req_valid = 1'b0; req_addr = 32'd0; req_uncached = 1'b0;
        idle_beat();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        fetch(32'h1000_0048, 1'b0);
        fetch(32'h1000_004C, 1'b0);
        hit_pair(32'h1000_0040, 32'h1000_0044);

        fetch(32'h2000_0040, 1'b0);
        fetch(32'h1000_0040, 1'b0);
        fetch(32'h3000_0040, 1'b0);
        fetch(32'h1000_0040, 1'b0);
        fetch(32'h2000_0040, 1'b0);

        fetch(32'hBFC0_0000, 1'b1);
        fetch(32'hBFC0_0000, 1'b1);

        @(negedge clk);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        model_reset();
        fetch(32'h1000_0040, 1'b0);

        // Flush mid-refill: remaining own beats are drained, nothing allocated.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h5000_0088; req_uncached = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'd0;
        @(negedge clk);
        rvalid = 1'b1; rid = 4'b0001; rlast = 1'b0; ram_data_i = 32'hDEAD_0001;
        @(negedge clk);
        rid = 4'b0000; ram_data_i = mem_word(32'h5000_0080);
        @(negedge clk);
        rid = 4'b0001; ram_data_i = 32'hDEAD_0002;
        @(negedge clk);
        rid = 4'b0000; ram_data_i = mem_word(32'h5000_0084);
        @(negedge clk);
        idle_beat();
        clear = 1'b1;
        #1;
        chk("clear_valid", inst_valid, 0);
        chk("clear_req", inst_req_o, 0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("drain_stall", stall, 1);
        chk("drain_req", inst_req_o, 0);
        rvalid = 1'b1; rid = 4'b0000; rlast = 1'b0; ram_data_i = 32'h1111_1111;
        #1;
        chk("drain_beat_valid", inst_valid, 0);
        @(negedge clk);
        rid = 4'b0001; rlast = 1'b1;
        #1;
        chk("drain_foreign_stall", stall, 1);
        @(negedge clk);
        rid = 4'b0000; rlast = 1'b1; ram_data_i = 32'h2222_2222;
        #1;
        chk("drain_last_valid", inst_valid, 0);
        chk("drain_last_stall", stall, 1);
        @(negedge clk);
        idle_beat();
        #1;
        chk("drain_done_stall", stall, 0);
        chk("drain_done_valid", inst_valid, 0);
        fetch(32'h5000_0088, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = 32'hBFC0_0000 + 32'(4 * $urandom_range(0, 15));
                fetch(a, 1'b1);
            end else begin
                a = 32'h1000_0000 * 32'($urandom_range(1, 4));
                a = a | 32'($urandom_range(4, 5) << 4) | 32'($urandom_range(0, 3) << 2);
                fetch(a, 1'b0);
            end
        end

        // Reset pulsed during a refill.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h6000_0040; req_uncached = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'd0;
        @(negedge clk);
        rvalid = 1'b1; rid = 4'b0000; rlast = 1'b0; ram_data_i = 32'h3333_3333;
        @(negedge clk);
        idle_beat();
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        fetch(32'h1000_0040, 1'b0);
        fetch(32'h5000_0088, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
